// File: rtl/bsg_mem_1r1w_sync_init_pkg.sv
// Shared types and helpers for the self-initialising 1R1W synchronous RAM.
// Holds the controller state encoding, the lane-to-bit mask expander and the address-width helper.
package bsg_mem_init_pkg;

   typedef enum logic {
      eInit  = 1'b0,
      eReady = 1'b1
   } bsg_mem_init_state_e;

   // Upper bounds for the generic lane expander; callers cast the result down to width_p.
   localparam int unsigned LANE_MAX_W = 1024;
   localparam int unsigned LANE_MAX_N = 128;

   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Lane k of the mask drives bits [k*lane_w +: lane_w] of the returned bit mask.
   function automatic logic [LANE_MAX_W-1:0] lane_expand(
      input logic [LANE_MAX_N-1:0] mask,
      input int unsigned           lane_w
   );
      logic [LANE_MAX_W-1:0] bits;
      int unsigned           idx;
      bits = '0;
      if (lane_w != 0) begin
         for (int unsigned b = 0; b < LANE_MAX_W; b++) begin
            idx = b / lane_w;
            if (idx < LANE_MAX_N) bits[b] = mask[idx[6:0]];
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync_init_if.sv
// User-side bus of the self-initialising RAM: write port, read port, init request and status.
// Handshake: a request (w_v_i / r_v_i) is taken in any cycle where ready_o=1, with no other backpressure; r_v_o marks r_data_o one cycle after an accepted read.
interface bsg_mem_1r1w_sync_init_if
   import bsg_mem_init_pkg::*;
#(
   parameter int unsigned width_p      = 32,
   parameter int unsigned els_p        = 12,
   parameter int unsigned mask_width_p = width_p / 8
) ();

   localparam int unsigned addr_width_lp = safe_clog2(els_p);

   logic                     init_i;
   logic                     ready_o;
   logic                     w_v_i;
   logic [addr_width_lp-1:0] w_addr_i;
   logic [width_p-1:0]       w_data_i;
   logic [mask_width_p-1:0]  w_mask_i;
   logic                     r_v_i;
   logic [addr_width_lp-1:0] r_addr_i;
   logic [width_p-1:0]       r_data_o;
   logic                     r_v_o;

   modport master (
      output init_i, w_v_i, w_addr_i, w_data_i, w_mask_i, r_v_i, r_addr_i,
      input  ready_o, r_data_o, r_v_o
   );

   modport slave (
      input  init_i, w_v_i, w_addr_i, w_data_i, w_mask_i, r_v_i, r_addr_i,
      output ready_o, r_data_o, r_v_o
   );

endinterface

// File: rtl/bsg_mem_1r1w_sync_init_ctrl.sv
// Sweep controller: owns the eInit/eReady FSM and the clearing counter, and muxes
// the sweep's zero writes with the user write port.
module bsg_mem_1r1w_sync_init_ctrl
   import bsg_mem_init_pkg::*;
#(
   parameter int unsigned width_p       = 32,
   parameter int unsigned els_p         = 12,
   parameter int unsigned mask_width_p  = width_p / 8,
   parameter int unsigned addr_width_lp = safe_clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     init_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [mask_width_p-1:0]  w_mask_i,
   input  logic                     r_v_i,
   output logic                     ready_o,
   output bsg_mem_init_state_e      state_o,
   output logic                     w_v_o,
   output logic [addr_width_lp-1:0] w_addr_o,
   output logic [width_p-1:0]       w_data_o,
   output logic [width_p-1:0]       w_bitmask_o,
   output logic                     r_accept_o
);

   localparam int unsigned             lane_w_lp   = width_p / mask_width_p;
   localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

   bsg_mem_init_state_e      r_state;
   bsg_mem_init_state_e      w_state_nxt;
   logic [addr_width_lp-1:0] r_count;
   logic [addr_width_lp-1:0] w_count_nxt;
   logic [width_p-1:0]       w_user_bitmask;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= eInit;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      case (r_state)
         eInit: begin
            if (init_i) begin
               w_count_nxt = '0;
            end else if (r_count == last_addr_lp) begin
               w_state_nxt = eReady;
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count + addr_width_lp'(1);
            end
         end
         eReady: begin
            if (init_i) begin
               w_state_nxt = eInit;
               w_count_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = eInit;
            w_count_nxt = '0;
         end
      endcase
   end

   assign w_user_bitmask = width_p'(lane_expand(LANE_MAX_N'(w_mask_i), lane_w_lp));

   // A read presented together with init_i is dropped so no result surfaces during the sweep;
   // the write in that cycle still lands and is later cleared.
   always_comb begin
      ready_o     = 1'b0;
      w_v_o       = 1'b0;
      w_addr_o    = r_count;
      w_data_o    = '0;
      w_bitmask_o = '1;
      r_accept_o  = 1'b0;
      case (r_state)
         eInit: begin
            w_v_o = 1'b1;
         end
         eReady: begin
            ready_o     = 1'b1;
            w_v_o       = w_v_i;
            w_addr_o    = w_addr_i;
            w_data_o    = w_data_i;
            w_bitmask_o = w_user_bitmask;
            r_accept_o  = r_v_i & ~init_i;
         end
         default: ;
      endcase
   end

   assign state_o = r_state;

endmodule

// File: rtl/bsg_mem_1r1w_sync_init.sv
// Synchronous 1R1W RAM with byte-lane writes, optional write-to-read forwarding and a
// hardware zeroing sweep after reset or on init request. One-cycle read latency with r_v_o.
module bsg_mem_1r1w_sync_init
   import bsg_mem_init_pkg::*;
#(
   parameter int unsigned width_p                = 32,
   parameter int unsigned els_p                  = 12,
   parameter int unsigned mask_width_p           = width_p / 8,
   parameter int unsigned read_write_same_addr_p = 0,
   parameter int unsigned latch_last_read_p      = 0
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   bsg_mem_1r1w_sync_init_if.slave  bus,
   output bsg_mem_init_state_e      debug_state_o
);

   localparam int unsigned addr_width_lp = safe_clog2(els_p);

   logic                     w_ready;
   logic                     w_ctrl_w_v;
   logic [addr_width_lp-1:0] w_ctrl_w_addr;
   logic [width_p-1:0]       w_ctrl_w_data;
   logic [width_p-1:0]       w_ctrl_w_bitmask;
   logic                     w_r_accept;
   logic                     w_w_in_range;
   logic                     w_r_in_range;
   logic                     w_mem_we;
   logic                     w_collide;
   logic [width_p-1:0]       w_mem_rd;
   logic [width_p-1:0]       w_merged;
   logic [width_p-1:0]       w_rd_value;

   logic [width_p-1:0]       r_mem [els_p];
   logic [width_p-1:0]       r_data;
   logic                     r_v;

   bsg_mem_1r1w_sync_init_ctrl #(
      .width_p       (width_p),
      .els_p         (els_p),
      .mask_width_p  (mask_width_p),
      .addr_width_lp (addr_width_lp)
   ) u_ctrl (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .init_i      (bus.init_i),
      .w_v_i       (bus.w_v_i),
      .w_addr_i    (bus.w_addr_i),
      .w_data_i    (bus.w_data_i),
      .w_mask_i    (bus.w_mask_i),
      .r_v_i       (bus.r_v_i),
      .ready_o     (w_ready),
      .state_o     (debug_state_o),
      .w_v_o       (w_ctrl_w_v),
      .w_addr_o    (w_ctrl_w_addr),
      .w_data_o    (w_ctrl_w_data),
      .w_bitmask_o (w_ctrl_w_bitmask),
      .r_accept_o  (w_r_accept)
   );

   assign w_w_in_range = (32'(w_ctrl_w_addr) < els_p);
   assign w_r_in_range = (32'(bus.r_addr_i) < els_p);
   assign w_mem_we     = w_ctrl_w_v & w_w_in_range;
   assign w_collide    = w_mem_we & w_r_accept & (bus.r_addr_i == w_ctrl_w_addr);

   always_ff @(posedge clk_i) begin
      if (w_mem_we)
         r_mem[w_ctrl_w_addr] <= (r_mem[w_ctrl_w_addr] & ~w_ctrl_w_bitmask)
                               | (w_ctrl_w_data & w_ctrl_w_bitmask);
   end

   // Out-of-range reads never index the array; they return zero.
   assign w_mem_rd = w_r_in_range ? r_mem[bus.r_addr_i] : '0;
   assign w_merged = (w_mem_rd & ~w_ctrl_w_bitmask) | (w_ctrl_w_data & w_ctrl_w_bitmask);

   always_comb begin
      w_rd_value = w_mem_rd;
      if (!w_r_in_range)
         w_rd_value = '0;
      else if (w_collide && (read_write_same_addr_p != 0))
         w_rd_value = w_merged;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_data <= '0;
         r_v    <= 1'b0;
      end else begin
         r_v <= w_r_accept;
         if (w_r_accept)
            r_data <= w_rd_value;
         else if (latch_last_read_p == 0)
            r_data <= '0;
      end
   end

   assign bus.ready_o  = w_ready;
   assign bus.r_data_o = r_data;
   assign bus.r_v_o    = r_v;

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (reset_n_i) begin
         if (w_ctrl_w_v)
            assert (w_w_in_range)
               else $warning("bsg_mem_1r1w_sync_init: write to address %0d beyond els_p=%0d dropped",
                             w_ctrl_w_addr, els_p);
         if (w_r_accept)
            assert (w_r_in_range)
               else $warning("bsg_mem_1r1w_sync_init: read of address %0d beyond els_p=%0d returns 0",
                             bus.r_addr_i, els_p);
         if (read_write_same_addr_p == 0)
            assert (!w_collide)
               else $error("bsg_mem_1r1w_sync_init: same-address read/write at %0d is illegal",
                           bus.r_addr_i);
      end
   end
`endif

endmodule

// File: doc/bsg_mem_1r1w_sync_init.md
# bsg_mem_1r1w_sync_init

Synchronous 1-read/1-write RAM with byte-masked writes, configurable write-to-read forwarding, and a hardware initialisation sweep that zeroes every entry after reset or on request. It replaces the plain sync 1R1W RAM wherever downstream logic (tag arrays, directories, predictor tables) needs known-clean contents without a software clear. Read latency is one cycle, with an explicit output-valid flag.

## Interface
- width_p, (required), data width in bits; must be a multiple of mask_width_p
- els_p, (required), number of entries; any value ≥ 2, not necessarily a power of two
- mask_width_p, width_p/8, number of write-mask lanes; lane k covers bits [k*(width_p/mask_width_p) +: width_p/mask_width_p]
- read_write_same_addr_p, 0, 1 = a same-address read returns the post-write (merged) data; 0 = collision is illegal
- latch_last_read_p, 0, 1 = r_data_o holds its last read value while no read is issued
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock; all state is updated on the rising edge
- reset_n_i  in  1  asynchronous active-low reset
- init_i  in  1  request a re-initialisation sweep
- ready_o  out  1  1 = sweep is idle and r_v_i/w_v_i are accepted
- w_v_i  in  1  write request
- w_addr_i  in  addr_width_lp  write address
- w_data_i  in  width_p  write data
- w_mask_i  in  mask_width_p  per-lane write enable
- r_v_i  in  1  read request
- r_addr_i  in  addr_width_lp  read address
- r_data_o  out  width_p  read data
- r_v_o  out  1  r_data_o carries the result of a read issued in the previous cycle

## Operation
- The FSM has two states, eInit and eReady. reset_n_i low forces eInit with the sweep counter at 0.
- In eInit:
  - Each cycle, write all-zero data with all lanes enabled to entry [counter], then increment the counter.
  - On the cycle the counter equals els_p-1, move to eReady.
  - ready_o=0. w_v_i and r_v_i are ignored, so no write happens and r_v_o stays 0.
  - init_i=1 in eInit resets the counter to 0, which restarts the sweep.
- In eReady:
  - ready_o=1.
  - init_i=1 moves to eInit with the counter at 0. The user write presented in that same cycle is still performed, and is then overwritten by the sweep.
- Write: when w_v_i is accepted, entry [w_addr_i] lanes with w_mask_i[k]=1 take w_data_i; the other lanes are unchanged. w_mask_i=0 is a legal no-op.
- Read: when r_v_i is accepted, r_data_o is the entry [r_addr_i] value on the next cycle, and r_v_o=1 on that cycle.
- Collision (both accepted, r_addr_i==w_addr_i):
  - read_write_same_addr_p=1: r_data_o returns the merged value, i.e. new lanes where masked and old lanes elsewhere.
  - read_write_same_addr_p=0: r_data_o is undefined. A simulation-only assertion fires, gated off while reset_n_i is low.
- Out-of-range address (≥ els_p):
  - The write is dropped.
  - The read returns 0 with r_v_o=1.
  - A simulation-only assertion fires in both cases.
- No read issued (r_v_i=0 or not accepted): r_v_o=0 on the next cycle. r_data_o holds its value if latch_last_read_p=1; otherwise it is undefined and unchecked.

## Timing
- Reset values: ready_o=0, r_v_o=0, r_data_o=0, state eInit, counter 0.
- First rising edge after reset_n_i deasserts = sweep cycle 0.
- The sweep writes entries 0..els_p-1 on cycles 0..els_p-1. ready_o=1 from cycle els_p onward. Total sweep length is exactly els_p cycles.
- Read latency is 1 cycle, with r_v_o aligned to r_data_o.
- Accepting a read or write is combinational on ready_o in the same cycle; there is no backpressure beyond ready_o.
- Reset asserted mid-sweep or mid-read:
  - Outputs return to their reset values immediately (asynchronously).
  - The sweep restarts from 0 after release.
  - Any pending read result is discarded.

## Structure
- Package bsg_mem_init_pkg:
  - state enum bsg_mem_init_state_e {eInit, eReady}
  - lane-expand helper function (mask_width_p → width_p bit mask)
- Sub-module bsg_mem_1r1w_sync_init_ctrl: FSM, sweep counter and ready_o. It outputs the muxed write port (v, addr, data, bit mask) and read-accept.
- Top level: the storage array, masked write, read register with bypass mux, latch-last-read hold, and assertions.

## Test plan
All scenarios use width_p=32, els_p=12 and mask_width_p=4 unless noted.
- **Reset sweep:** release reset_n_i, then read every address. Expected: ready_o rises exactly 12 cycles after release, and all 12 reads return 0x00000000 with r_v_o=1 one cycle after each request.
- **Masked write:** write 0xAABBCCDD to addr 5 with mask 4'b1111, then 0x11223344 with mask 4'b0101, then read addr 5. Expected: 0xAA22CC44.
- **Forwarding (read_write_same_addr_p=1):** addr 3 holds 0x01020304; in the same cycle, write 0xFFFFFFFF with mask 4'b1000 and read addr 3. Expected: next-cycle r_data_o=0xFF020304.
- **Re-init:** write 0xDEADBEEF to addr 11; pulse init_i; in the init cycle, also assert r_v_i for addr 11. Expected: ready_o=0 for 12 cycles, no r_v_o during the sweep, and a read of addr 11 afterwards returns 0.
- **Async reset mid-sweep and latch (latch_last_read_p=1):** assert reset_n_i at sweep cycle 6. Expected: outputs go to 0 immediately and the sweep restarts at 0. After ready, read 0x0 then idle 5 cycles. Expected: r_data_o holds the value and r_v_o=0 throughout.
- **Out-of-range:** with els_p=12, write addr 13 then read addr 13. Expected: storage unchanged, read returns 0 with r_v_o=1, and the assertion is logged.
